// File: rtl/ir_cmd_decoder.sv
// rtl/ir_cmd_decoder.sv - NEC IR word stability filter, validator and snake direction committer (optional stats: IR_CMD_STATS_EN)
module ir_cmd_decoder #(
    parameter int          STABLE_CYCLES = 16,
    parameter logic [15:0] NEC_ADDR      = 16'h20DF,
    parameter logic [7:0]  KEY_UP        = 8'h02,
    parameter logic [7:0]  KEY_DOWN      = 8'h82,
    parameter logic [7:0]  KEY_LEFT      = 8'hE0,
    parameter logic [7:0]  KEY_RIGHT     = 8'h60,
    parameter logic [7:0]  KEY_OK        = 8'h22
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [31:0] word,
    input  logic        game_tick,
    output logic [1:0]  dir,
    output logic        dir_changed,
    output logic        start_pulse,
    output logic        cmd_valid
`ifdef IR_CMD_STATS_EN
    ,
    output logic [7:0]  reject_count
`endif
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DECODE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] w_q, w_d;
    logic [31:0] last_word_q, last_word_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  pending_q, pending_d;
    logic [1:0]  dir_q, dir_d;
    logic        dir_changed_q, dir_changed_d;
    logic        start_pulse_q, start_pulse_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        frame_ok;
    logic [7:0]  cmd_byte;
`ifdef IR_CMD_STATS_EN
    logic [7:0]  reject_q, reject_d;
`endif

    // The latched word is decoded rather than w_q, so a change arriving during
    // DECODE cannot be mixed into the frame that was just qualified as stable.
    assign cmd_byte = last_word_q[15:8];
    assign frame_ok = (last_word_q[31:16] == NEC_ADDR) &&
                      (last_word_q[15:8] == ~last_word_q[7:0]);

    // Next-state: stability counter, settle/decode FSM, pending key and tick-time commit
    always_comb begin
        w_d           = word;
        cnt_d         = cnt_q;
        state_d       = state_q;
        last_word_d   = last_word_q;
        pending_d     = pending_q;
        dir_d         = dir_q;
        dir_changed_d = 1'b0;
        start_pulse_d = 1'b0;
        cmd_valid_d   = 1'b0;
`ifdef IR_CMD_STATS_EN
        reject_d      = reject_q;
`endif

        if (word != w_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q != STABLE_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_q != last_word_q) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == STABLE_MAX) begin
                    last_word_d = w_q;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_IDLE;
                if (last_word_q == 32'd0) begin
                    // released-key word: nothing to report
                end else if (!frame_ok) begin
`ifdef IR_CMD_STATS_EN
                    if (reject_q != 8'hFF) begin
                        reject_d = reject_q + 8'd1;
                    end
`endif
                end else begin
                    cmd_valid_d = 1'b1;
                    if (cmd_byte == KEY_UP) begin
                        pending_d = DIR_UP;
                    end else if (cmd_byte == KEY_DOWN) begin
                        pending_d = DIR_DOWN;
                    end else if (cmd_byte == KEY_LEFT) begin
                        pending_d = DIR_LEFT;
                    end else if (cmd_byte == KEY_RIGHT) begin
                        pending_d = DIR_RIGHT;
                    end else if (cmd_byte == KEY_OK) begin
                        start_pulse_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Commit uses the registered pending value, so a key decoded in the
        // same cycle as the tick waits for the next tick.
        if (game_tick && (pending_q != dir_q) && (pending_q != (dir_q ^ 2'b10))) begin
            dir_d         = pending_q;
            dir_changed_d = 1'b1;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= S_IDLE;
            w_q           <= 32'd0;
            last_word_q   <= 32'd0;
            cnt_q         <= 8'd0;
            pending_q     <= DIR_RIGHT;
            dir_q         <= DIR_RIGHT;
            dir_changed_q <= 1'b0;
            start_pulse_q <= 1'b0;
            cmd_valid_q   <= 1'b0;
`ifdef IR_CMD_STATS_EN
            reject_q      <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            w_q           <= w_d;
            last_word_q   <= last_word_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            dir_q         <= dir_d;
            dir_changed_q <= dir_changed_d;
            start_pulse_q <= start_pulse_d;
            cmd_valid_q   <= cmd_valid_d;
`ifdef IR_CMD_STATS_EN
            reject_q      <= reject_d;
`endif
        end
    end

    assign dir         = dir_q;
    assign dir_changed = dir_changed_q;
    assign start_pulse = start_pulse_q;
    assign cmd_valid   = cmd_valid_q;
`ifdef IR_CMD_STATS_EN
    assign reject_count = reject_q;
`endif

endmodule

// File: tb/tb_ir_cmd_decoder.sv
// tb/tb_ir_cmd_decoder.sv - directed self-checking bench for ir_cmd_decoder
module tb_ir_cmd_decoder;

    localparam int STABLE = 16;
    // k=1 is the edge that first samples a new word; pulse lands at t+STABLE+2
    localparam int LAT = STABLE + 3;

    localparam logic [31:0] W_OK    = 32'h20DF22DD;
    localparam logic [31:0] W_UP    = 32'h20DF02FD;
    localparam logic [31:0] W_DOWN  = 32'h20DF827D;
    localparam logic [31:0] W_LEFT  = 32'h20DFE01F;
    localparam logic [31:0] W_RIGHT = 32'h20DF609F;
    localparam logic [31:0] W_BADCS = 32'h20DF0203;
    localparam logic [31:0] W_BADAD = 32'h123402FD;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] word;
    logic        game_tick;
    logic [1:0]  dir;
    logic        dir_changed;
    logic        start_pulse;
    logic        cmd_valid;
`ifdef IR_CMD_STATS_EN
    logic [7:0]  reject_count;
`endif

    int total = 0;
    int bad   = 0;
    int cv_n  = 0;
    int sp_n  = 0;
    int dc_n  = 0;
    int cv0, sp0, dc0, first_cv, first_sp;

    ir_cmd_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .word        (word),
        .game_tick   (game_tick),
        .dir         (dir),
        .dir_changed (dir_changed),
        .start_pulse (start_pulse),
        .cmd_valid   (cmd_valid)
`ifdef IR_CMD_STATS_EN
        ,
        .reject_count(reject_count)
`endif
    );

    always #5 clk = ~clk;

    // pulse counters sampled away from the active edge
    always @(negedge clk) begin
        cv_n += int'(cmd_valid);
        sp_n += int'(start_pulse);
        dc_n += int'(dir_changed);
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        game_tick = 1'b1;
        step();
        game_tick = 1'b0;
    endtask

    // measure first cycle of cmd_valid/start_pulse after a new word, bounded to 40 edges
    task automatic measure();
        first_cv = 0;
        first_sp = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (cmd_valid && first_cv == 0) first_cv = k;
            if (start_pulse && first_sp == 0) first_sp = k;
        end
    endtask

    initial begin
        reset     = 1'b1;
        word      = 32'd0;
        game_tick = 1'b0;
        step(3);
        check("reset_dir", 32'(dir), 32'h1);
        check("reset_cmd_valid", 32'(cmd_valid), 32'h0);
        check("reset_start", 32'(start_pulse), 32'h0);
        check("reset_dir_changed", 32'(dir_changed), 32'h0);
`ifdef IR_CMD_STATS_EN
        check("reset_rejects", 32'(reject_count), 32'h0);
`endif
        reset = 1'b0;
        step(2);

        // OK key: one start_pulse and one cmd_valid at the fixed latency
        cv0 = cv_n; sp0 = sp_n;
        word = W_OK;
        measure();
        check("ok_cv_latency", 32'(first_cv), 32'(LAT));
        check("ok_sp_latency", 32'(first_sp), 32'(LAT));
        check("ok_cv_count", 32'(cv_n - cv0), 32'd1);
        check("ok_sp_count", 32'(sp_n - sp0), 32'd1);
        check("ok_dir", 32'(dir), 32'h1);

        // up, then tick: 01 -> 00 with one dir_changed pulse
        cv0 = cv_n; sp0 = sp_n;
        word = W_UP;
        step(25);
        check("up_cv_count", 32'(cv_n - cv0), 32'd1);
        check("up_no_start", 32'(sp_n - sp0), 32'd0);
        check("up_dir_before_tick", 32'(dir), 32'h1);
        dc0 = dc_n;
        tick();
        check("up_dir_after_tick", 32'(dir), 32'h0);
        check("up_dir_changed", 32'(dir_changed), 32'h1);
        step();
        check("up_dir_changed_drop", 32'(dir_changed), 32'h0);
        check("up_dc_count", 32'(dc_n - dc0), 32'd1);

        // down from up is a reversal: no commit, no pulse
        word = W_DOWN;
        step(25);
        dc0 = dc_n;
        tick();
        step(2);
        check("down_dir_held", 32'(dir), 32'h0);
        check("down_no_dc", 32'(dc_n - dc0), 32'd0);

        // toggling every 10 cycles never settles; holding it settles once
        cv0 = cv_n;
        for (int i = 0; i < 20; i++) begin
            word = (i % 2 == 0) ? W_LEFT : W_RIGHT;
            step(10);
        end
        check("toggle_no_cv", 32'(cv_n - cv0), 32'd0);
        step(30);
        check("toggle_hold_one_cv", 32'(cv_n - cv0), 32'd1);

        // bad checksum and wrong address are rejected
        cv0 = cv_n;
        word = W_BADCS;
        step(30);
        word = W_BADAD;
        step(30);
        check("bad_no_cv", 32'(cv_n - cv0), 32'd0);
`ifdef IR_CMD_STATS_EN
        check("bad_reject_count", 32'(reject_count), 32'd2);
`endif

        // pending is right (01) from the toggle hold, dir is up: commits 01
        tick();
        check("right_commit", 32'(dir), 32'h1);
        check("right_dc", 32'(dir_changed), 32'h1);

        // up then left from right: left is pending last, and left reverses right
        word = W_UP;
        step(25);
        word = W_LEFT;
        step(25);
        dc0 = dc_n;
        tick();
        step(2);
        check("up_left_reversal_dir", 32'(dir), 32'h1);
        check("up_left_reversal_dc", 32'(dc_n - dc0), 32'd0);

        // left then up from right: up wins and commits
        word = W_DOWN;
        step(25);
        word = W_LEFT;
        step(25);
        word = W_UP;
        step(25);
        dc0 = dc_n;
        tick();
        step(2);
        check("last_wins_dir", 32'(dir), 32'h0);
        check("last_wins_dc", 32'(dc_n - dc0), 32'd1);

        // reset in the middle of SETTLE aborts; release re-decodes the held word
        word = W_OK;
        step(9);
        cv0 = cv_n; sp0 = sp_n;
        reset = 1'b1;
        step(3);
        check("abort_dir", 32'(dir), 32'h1);
        check("abort_no_cv", 32'(cv_n - cv0), 32'd0);
        check("abort_no_sp", 32'(sp_n - sp0), 32'd0);
        reset = 1'b0;
        measure();
        check("rerun_sp_latency", 32'(first_sp), 32'(LAT));
        check("rerun_sp_count", 32'(sp_n - sp0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
